wb_daq_dma_writer: RTL and testbench
====================================

# wb_daq_dma_writer

Single-channel sample-to-memory mover sitting between a DAQ sample source and the shared Wishbone RAM that `wb_dsp_top` reads from. It buffers incoming ADC sample words in a small FIFO. It writes them as Wishbone classic single writes to consecutive word addresses starting at a programmed base, for a programmed word count. It pulses `done` when the whole buffer is written, so the DSP can be kicked.

## Interface
- `FIFO_DEPTH`, default 4: sample FIFO entries. Must be a power of two, ≥2.
- `AW`, default 32: Wishbone address width, byte addressing.
- `DW`, default 32: data width. Fixed 32; `wb_sel_o` is 4 bits.
- `wb_clk` in 1: the only clock. All logic is on its rising edge.
- `wb_rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse. Latches `base_adr`/`length` and begins a transfer. Ignored while `busy`.
- `base_adr` in AW: byte address of the first word. Bits [1:0] are ignored (treated as 0).
- `length` in 16: number of words to write.
- `sample_dat_i` in DW: sample word.
- `sample_valid_i` in 1: sample present.
- `sample_ready_o` out 1: FIFO will accept the sample this cycle.
- `wb_adr_o` out AW, `wb_dat_o` out DW, `wb_sel_o` out 4, `wb_we_o` out 1, `wb_cyc_o` out 1, `wb_stb_o` out 1, `wb_cti_o` out 3, `wb_bte_o` out 2: Wishbone master outputs.
- `wb_dat_i` in DW (unused), `wb_ack_i` in 1, `wb_err_i` in 1, `wb_rty_i` in 1: Wishbone master inputs.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky bus error flag. Cleared by the next accepted `start`.
- `words_written` out 16: count of words acked in the current or last transfer.

## Operation
- States are IDLE, FETCH, WRITE, DONE and ERR.
- IDLE: on `start`:
  - latch the address (word aligned) and `length` into `remaining`;
  - flush the FIFO;
  - clear `words_written` and `error`;
  - go to DONE if `length==0`, else go to FETCH.
- FETCH: while the FIFO is empty, wait. When it is non-empty, drive the head entry onto `wb_dat_o` and the current address onto `wb_adr_o`, assert `cyc`/`stb`, and go to WRITE.
- WRITE: hold all bus outputs stable until a terminating input arrives.
  - `wb_ack_i`: pop the FIFO, address += 4, `remaining` −= 1, `words_written` += 1, drop `cyc`/`stb`. Go to DONE if `remaining` was 1, else go to FETCH.
  - `wb_rty_i` (no ack): drop `cyc`/`stb`, go to FETCH. The same word is retried; nothing is popped or counted.
  - `wb_err_i`: drop `cyc`/`stb`, set `error`, go to ERR. Priority is err > ack > rty.
- DONE: pulse `done` for one cycle, then go to IDLE.
- ERR: one cycle, then go to IDLE. `done` is not pulsed. The FIFO is flushed on the next `start`.
- Fixed bus outputs during a write: `wb_we_o=1`, `wb_sel_o=4'hF`, `wb_cti_o=3'b000`, `wb_bte_o=2'b00`.
- `busy` = state != IDLE.
- `sample_ready_o` = `busy` && FIFO not full. Samples offered outside a transfer are not accepted.
- FIFO push and pop in the same cycle are both legal. Occupancy is unchanged and ordering is preserved.
- Address arithmetic wraps modulo 2^AW. No boundary checking.
- `words_written` stops at `length`. No wrap is possible since `length` ≤ 65535.

## Timing
- All outputs are registered except `sample_ready_o`, which is combinational from state and FIFO occupancy.
- Reset values, after the clock edge with `wb_rst=1`:
  - state IDLE, FIFO empty;
  - `wb_cyc_o`/`wb_stb_o`/`wb_we_o`=0, `wb_adr_o`/`wb_dat_o`=0, `wb_sel_o`=0, `wb_cti_o`=0, `wb_bte_o`=0;
  - `busy`=0, `done`=0, `error`=0, `words_written`=0.
- Reset mid-cycle drops `cyc`/`stb` at that edge and abandons the transfer. No `done`.
- `start` at edge N: `busy`=1 from N+1. The first `cyc`/`stb` comes no earlier than N+2, one cycle after the first push.
- Ack sampled at edge M: `cyc`/`stb` are low in the cycle after M. The next word's `cyc` rises at M+2 at the earliest. Throughput is one word per (2 + slave wait states) cycles.
- `done` is high for exactly the one cycle after the final ack. `busy` falls one cycle later.
- A `start` coincident with `done`/ERR is ignored, because `busy`=1.

## Test plan
- **Basic write.** `base_adr=0x100`, `length=4`, samples 0xA0..0xA3 streamed back-to-back against `wb_ram` → RAM words 0x100..0x10C hold A0..A3. Exactly 4 write cycles. One `done` pulse. `words_written=4`.
- **Backpressure.** `FIFO_DEPTH=4`, slave ack delayed 10 cycles, 8 samples offered continuously → `sample_ready_o` low while 4 entries are held. No sample lost or duplicated. Order is preserved.
- **Retry.** Slave asserts `rty` on the 2nd word once, then acks → the same address and data are re-issued. `words_written=length`. Memory is correct.
- **Error.** `err` on the 3rd word of 5 → `error`=1. No `done`. `words_written=2`, back in IDLE. The next `start` clears `error` and completes normally.
- **Length zero and start while busy.** `length=0` → `done` the cycle after `busy` rises, no bus cycle. A second `start` during a transfer → ignored, addresses unchanged.
- **Reset mid-write.** `wb_rst` asserted while `cyc`=1 → `cyc`/`stb`/`busy` are 0 after the edge. The FIFO is empty. A new transfer succeeds.

Source files
------------

// File: rtl/wb_daq_dma_writer.sv
// Single-channel DAQ sample mover. Samples are buffered in a small FIFO and written
// to consecutive Wishbone word addresses as classic single writes, then done pulses.
module wb_daq_dma_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          start,
  input  logic [AW-1:0] base_adr,
  input  logic [15:0]   length,
  input  logic [DW-1:0] sample_dat_i,
  input  logic          sample_valid_i,
  output logic          sample_ready_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_written
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, DONE, ERR} state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [15:0]   remaining;

  logic [DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          flush;
  logic          unused_inputs;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign sample_ready_o = (state != IDLE) && !fifo_full;
  assign push           = sample_valid_i && sample_ready_o;
  assign pop            = (state == WRITE) && wb_ack_i && !wb_err_i;
  assign flush          = (state == IDLE) && start;
  assign unused_inputs  = ^{wb_dat_i, base_adr[1:0]};

  always_ff @(posedge wb_clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= sample_dat_i;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      words_written <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
      wb_we_o       <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_cti_o      <= '0;
      wb_bte_o      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr          <= {base_adr[AW-1:2], 2'b00};
            remaining     <= length;
            words_written <= '0;
            error         <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b1;
            state         <= (length == 16'd0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (!fifo_empty) begin
            wb_adr_o <= addr;
            wb_dat_o <= fifo_mem[rd_ptr[PW-1:0]];
            wb_sel_o <= 4'hF;
            wb_we_o  <= 1'b1;
            wb_cti_o <= 3'b000;
            wb_bte_o <= 2'b00;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          // Termination priority is err, then ack, then retry.
          if (wb_err_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            error    <= 1'b1;
            state    <= ERR;
          end else if (wb_ack_i) begin
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_sel_o      <= '0;
            addr          <= addr + AW'(4);
            remaining     <= remaining - 16'd1;
            words_written <= words_written + 16'd1;
            if (remaining == 16'd1) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= FETCH;
            end
          end else if (wb_rty_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            state    <= FETCH;
          end
        end
        DONE: begin
          // A zero-length transfer enters here with done low and raises it one cycle later.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_daq_dma_writer.sv
// Self-checking bench for wb_daq_dma_writer: transaction-level model of the mover,
// a Wishbone RAM slave with wait/retry/error injection, and a sample source.
module tb_wb_daq_dma_writer;

  localparam int DEPTH = 4;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] length;
  logic [31:0] sample_dat_i;
  logic        sample_valid_i;
  logic        sample_ready_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  always #5 wb_clk = ~wb_clk;

  wb_daq_dma_writer #(.FIFO_DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .base_adr(base_adr), .length(length),
    .sample_dat_i(sample_dat_i), .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .busy(busy), .done(done), .error(error), .words_written(words_written)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Wishbone RAM slave with programmable wait states and one-shot retry / error injection.
  logic [31:0] mem [logic [31:0]];
  int slv_wait = 0;
  int rty_word = -1;
  int err_word = -1;
  int slv_acks = 0;
  int wait_cnt = 0;
  bit rty_used = 1'b0;

  function automatic logic [31:0] memAt(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    forever begin
      @(posedge wb_clk);
      #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
      if (wb_cyc_o && wb_stb_o) begin
        if (wait_cnt >= slv_wait) begin
          wait_cnt = 0;
          if (slv_acks == err_word) begin
            wb_err_i = 1'b1;
          end else if (slv_acks == rty_word && !rty_used) begin
            wb_rty_i = 1'b1;
            rty_used = 1'b1;
          end else begin
            wb_ack_i = 1'b1;
            mem[wb_adr_o] = wb_dat_o;
            slv_acks++;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Sample source: offers src[] in order, advancing only on an accepted handshake.
  logic [31:0] src [$];
  int src_idx = 0;

  initial begin
    bit hs;
    sample_valid_i = 1'b0;
    sample_dat_i   = '0;
    forever begin
      @(negedge wb_clk);
      hs = sample_valid_i && sample_ready_o;
      @(posedge wb_clk);
      #2;
      if (hs) src_idx++;
      if (src_idx < src.size()) begin
        sample_valid_i = 1'b1;
        sample_dat_i   = src[src_idx];
      end else begin
        sample_valid_i = 1'b0;
      end
    end
  end

  // Transaction-level model: what was accepted, how many words acked, and the
  // done / error / busy obligations that follow from those events.
  logic [31:0] mq [$];
  logic [31:0] m_base = '0;
  int  m_len = 0;
  int  m_acked = 0;
  bit  m_busy = 1'b0;
  bit  m_done = 1'b0;
  bit  m_error = 1'b0;
  bit  m_zero = 1'b0;
  bit  m_err_end = 1'b0;
  bit  m_gap = 1'b0;
  bit  prev_cyc = 1'b0;
  bit  saw_bp = 1'b0;
  int  n_rise = 0;
  int  n_done = 0;

  initial begin
    int  occ;
    bit  exp_ready;
    bit  allowed;
    bit  push;
    forever begin
      @(negedge wb_clk);
      occ       = mq.size() - m_acked;
      exp_ready = m_busy && (occ < DEPTH);
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("error", 32'(error), 32'(m_error));
      checkOutput("words_written", 32'(words_written), 32'(m_acked));
      checkOutput("sample_ready", 32'(sample_ready_o), 32'(exp_ready));
      if (m_gap) checkOutput("cyc_after_term", 32'(wb_cyc_o), 32'd0);
      if (wb_cyc_o) begin
        allowed = m_busy && !m_done && !m_zero && !m_err_end && (occ > 0);
        checkOutput("cyc_allowed", 32'(allowed), 32'd1);
        checkOutput("stb", 32'(wb_stb_o), 32'd1);
        checkOutput("we", 32'(wb_we_o), 32'd1);
        checkOutput("sel", 32'(wb_sel_o), 32'hF);
        checkOutput("cti", 32'(wb_cti_o), 32'd0);
        checkOutput("bte", 32'(wb_bte_o), 32'd0);
        if (occ > 0) begin
          checkOutput("adr", wb_adr_o, m_base + 32'(4 * m_acked));
          checkOutput("dat", wb_dat_o, mq[m_acked]);
        end
      end else begin
        checkOutput("stb_idle", 32'(wb_stb_o), 32'd0);
      end
      if (wb_cyc_o && !prev_cyc) n_rise++;
      prev_cyc = wb_cyc_o;
      if (done) n_done++;
      if (m_busy && sample_valid_i && !sample_ready_o) saw_bp = 1'b1;

      if (wb_rst) begin
        mq.delete();
        m_acked = 0; m_busy = 1'b0; m_done = 1'b0; m_error = 1'b0;
        m_zero = 1'b0; m_err_end = 1'b0; m_gap = 1'b1;
      end else begin
        push  = sample_valid_i && exp_ready;
        m_gap = wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i || wb_rty_i);
        if (!m_busy) begin
          if (start) begin
            mq.delete();
            m_base = base_adr & ~32'h3;
            m_len = int'(length); m_acked = 0; m_busy = 1'b1; m_done = 1'b0;
            m_error = 1'b0; m_err_end = 1'b0; m_zero = (length == 16'd0);
          end
        end else if (m_done) begin
          m_done = 1'b0; m_busy = 1'b0;
        end else if (m_err_end) begin
          m_err_end = 1'b0; m_busy = 1'b0;
        end else if (m_zero) begin
          m_zero = 1'b0; m_done = 1'b1;
        end else if (wb_cyc_o && wb_stb_o) begin
          if (wb_err_i) begin
            m_error = 1'b1; m_err_end = 1'b1;
          end else if (wb_ack_i) begin
            m_acked++;
            if (m_acked == m_len) m_done = 1'b1;
          end
        end
        if (push) mq.push_back(sample_dat_i);
      end
    end
  end

  task automatic setupTest(input int wait_states, input int rty_at, input int err_at,
                           input logic [31:0] first, input int count);
    @(negedge wb_clk);
    slv_wait = wait_states; rty_word = rty_at; err_word = err_at;
    rty_used = 1'b0; slv_acks = 0;
    src.delete();
    for (int i = 0; i < count; i++) src.push_back(first + 32'(i));
    src_idx = 0; n_rise = 0; n_done = 0; saw_bp = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] base, input logic [15:0] len);
    @(posedge wb_clk);
    #2;
    start = 1'b1; base_adr = base; length = len;
    @(posedge wb_clk);
    #2;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int k = 0;
    do begin
      @(negedge wb_clk);
      k++;
    end while (busy && k < budget);
    checkOutput({name, "_timeout_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    wb_rst = 1'b1; start = 1'b0; base_adr = '0; length = '0; wb_dat_i = '0;
    @(posedge wb_clk);
    @(negedge wb_clk);
    checkOutput("rst_cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("rst_stb", 32'(wb_stb_o), 32'd0);
    checkOutput("rst_we", 32'(wb_we_o), 32'd0);
    checkOutput("rst_adr", wb_adr_o, 32'd0);
    checkOutput("rst_dat", wb_dat_o, 32'd0);
    checkOutput("rst_sel", 32'(wb_sel_o), 32'd0);
    checkOutput("rst_cti", 32'(wb_cti_o), 32'd0);
    checkOutput("rst_bte", 32'(wb_bte_o), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_words", 32'(words_written), 32'd0);
    @(posedge wb_clk);
    #2 wb_rst = 1'b0;

    $display("[TB] basic write");
    setupTest(0, -1, -1, 32'hA0, 4);
    applyStimulus(32'h100, 16'd4);
    waitIdle("basic", 200);
    for (int i = 0; i < 4; i++) checkOutput("basic_mem", memAt(32'h100 + 32'(4 * i)), 32'hA0 + 32'(i));
    checkOutput("basic_cycles", 32'(n_rise), 32'd4);
    checkOutput("basic_done_pulses", 32'(n_done), 32'd1);
    checkOutput("basic_words", 32'(words_written), 32'd4);

    $display("[TB] backpressure, unaligned base");
    setupTest(10, -1, -1, 32'hB0, 8);
    applyStimulus(32'h203, 16'd8);
    waitIdle("bp", 400);
    for (int i = 0; i < 8; i++) checkOutput("bp_mem", memAt(32'h200 + 32'(4 * i)), 32'hB0 + 32'(i));
    checkOutput("bp_seen", 32'(saw_bp), 32'd1);
    checkOutput("bp_words", 32'(words_written), 32'd8);

    $display("[TB] retry");
    setupTest(1, 1, -1, 32'hC0, 4);
    applyStimulus(32'h300, 16'd4);
    waitIdle("rty", 300);
    for (int i = 0; i < 4; i++) checkOutput("rty_mem", memAt(32'h300 + 32'(4 * i)), 32'hC0 + 32'(i));
    checkOutput("rty_cycles", 32'(n_rise), 32'd5);
    checkOutput("rty_words", 32'(words_written), 32'd4);

    $display("[TB] bus error then recovery");
    setupTest(0, -1, 2, 32'hD0, 5);
    applyStimulus(32'h400, 16'd5);
    waitIdle("err", 200);
    checkOutput("err_flag", 32'(error), 32'd1);
    checkOutput("err_done_pulses", 32'(n_done), 32'd0);
    checkOutput("err_words", 32'(words_written), 32'd2);
    checkOutput("err_mem1", memAt(32'h404), 32'hD1);
    checkOutput("err_mem2_unwritten", memAt(32'h408), 32'hDEAD_BEEF);
    setupTest(0, -1, -1, 32'hE0, 2);
    applyStimulus(32'h500, 16'd2);
    waitIdle("err_recover", 200);
    checkOutput("recover_error", 32'(error), 32'd0);
    checkOutput("recover_mem0", memAt(32'h500), 32'hE0);
    checkOutput("recover_mem1", memAt(32'h504), 32'hE1);
    checkOutput("recover_done_pulses", 32'(n_done), 32'd1);

    $display("[TB] zero length, start while busy");
    setupTest(0, -1, -1, 32'h0, 0);
    applyStimulus(32'h600, 16'd0);
    waitIdle("zero", 50);
    checkOutput("zero_cycles", 32'(n_rise), 32'd0);
    checkOutput("zero_done_pulses", 32'(n_done), 32'd1);
    setupTest(3, -1, -1, 32'hF0, 3);
    applyStimulus(32'h700, 16'd3);
    repeat (4) @(posedge wb_clk);
    applyStimulus(32'h800, 16'd1);
    waitIdle("busy_start", 300);
    for (int i = 0; i < 3; i++) checkOutput("busy_start_mem", memAt(32'h700 + 32'(4 * i)), 32'hF0 + 32'(i));
    checkOutput("busy_start_ignored", memAt(32'h800), 32'hDEAD_BEEF);
    checkOutput("busy_start_words", 32'(words_written), 32'd3);

    $display("[TB] address wrap");
    setupTest(0, -1, -1, 32'h11, 3);
    applyStimulus(32'hFFFF_FFF8, 16'd3);
    waitIdle("wrap", 200);
    checkOutput("wrap_mem0", memAt(32'hFFFF_FFF8), 32'h11);
    checkOutput("wrap_mem1", memAt(32'hFFFF_FFFC), 32'h12);
    checkOutput("wrap_mem2", memAt(32'h0000_0000), 32'h13);

    $display("[TB] reset mid-write");
    setupTest(20, -1, -1, 32'h44, 2);
    applyStimulus(32'h900, 16'd2);
    begin
      int k = 0;
      do begin
        @(negedge wb_clk);
        k++;
      end while (!wb_cyc_o && k < 30);
      checkOutput("rst_mid_cyc_seen", 32'(wb_cyc_o), 32'd1);
    end
    @(posedge wb_clk);
    #2 wb_rst = 1'b1;
    @(posedge wb_clk);
    @(negedge wb_clk);
    checkOutput("rst_mid_cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("rst_mid_stb", 32'(wb_stb_o), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_done", 32'(done), 32'd0);
    @(posedge wb_clk);
    #2 wb_rst = 1'b0;
    setupTest(0, -1, -1, 32'h66, 2);
    applyStimulus(32'hA00, 16'd2);
    waitIdle("after_rst", 200);
    checkOutput("after_rst_mem0", memAt(32'hA00), 32'h66);
    checkOutput("after_rst_mem1", memAt(32'hA04), 32'h67);
    checkOutput("rst_abandoned", memAt(32'h900), 32'hDEAD_BEEF);
    checkOutput("after_rst_done_pulses", 32'(n_done), 32'd1);

    repeat (3) @(negedge wb_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
